// File: rtl/tx_frame_buffer.sv
// Transmit frame buffer: host bytes are staged in a RAM, committed as frames through
// a length queue, and streamed downstream one byte per cycle over valid/ready.
module tx_frame_buffer #(
    parameter int ADDR_W = 9,
    parameter int SLOT_W = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tx_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_data_we,
    input  logic        i_push_write_index,
    input  logic        i_pop_write_index,
    input  logic        i_push_frame,
    output logic [15:0] o_data_size,
    output logic [7:0]  o_frames_count,
    output logic [15:0] o_status,
    output logic [7:0]  o_byte,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sof,
    output logic        o_eof
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int SLOTS = 1 << SLOT_W;

    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [SLOT_W:0]   qcnt_t;
    typedef logic [SLOT_W-1:0] qptr_t;

    localparam cnt_t  CNT_ONE  = cnt_t'(1);
    localparam cnt_t  CNT_TWO  = cnt_t'(2);
    localparam cnt_t  CNT_FULL = cnt_t'(DEPTH);
    localparam ptr_t  PTR_ONE  = ptr_t'(1);
    localparam qptr_t QP_ONE   = qptr_t'(1);
    localparam qcnt_t QC_ONE   = qcnt_t'(1);
    localparam qcnt_t QC_FULL  = qcnt_t'(SLOTS);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DATA = 2'd2} fsm_t;

    // All resettable state lives in one struct so both resets clear it identically.
    typedef struct packed {
        fsm_t       fsm;
        ptr_t       wr_ptr;
        ptr_t       rd_ptr;
        ptr_t       mark;
        cnt_t       occ;
        cnt_t       ucnt;
        cnt_t       mark_cnt;
        cnt_t       remaining;
        qptr_t      q_wr;
        qptr_t      q_rd;
        qcnt_t      q_cnt;
        qcnt_t      frames;
        logic [7:0] sent;
        logic [7:0] dout;
        logic       valid;
        logic       sof;
        logic       eof;
        logic       ovf;
        logic       qovf;
        logic       empty_err;
    } regs_t;

    regs_t      r;
    logic [7:0] mem   [DEPTH];
    cnt_t       len_q [SLOTS];

    logic full, q_full, wr_en, commit_ok, accept, last_accept, q_pop;
    ptr_t wr_ptr_a, wr_ptr_b;
    cnt_t ucnt_a, ucnt_b, occ_n, len_head;

    assign full        = (r.occ == CNT_FULL);
    // A slot stays in use until its frame's last byte is accepted.
    assign q_full      = (r.frames == QC_FULL);
    assign wr_en       = i_tx_rst_n && i_data_we && !full;
    assign accept      = (r.fsm == DATA) && r.valid && i_ready;
    assign last_accept = accept && (r.remaining == CNT_ONE);
    assign q_pop       = (r.fsm == LOAD);
    assign len_head    = len_q[r.q_rd];

    // Same-cycle host ordering: write, pop mark, push mark, commit.
    always_comb begin
        wr_ptr_a = r.wr_ptr;
        ucnt_a   = r.ucnt;
        if (wr_en) begin
            wr_ptr_a = r.wr_ptr + PTR_ONE;
            ucnt_a   = r.ucnt + CNT_ONE;
        end
        wr_ptr_b = wr_ptr_a;
        ucnt_b   = ucnt_a;
        if (i_pop_write_index) begin
            wr_ptr_b = r.mark;
            ucnt_b   = r.mark_cnt;
        end
        commit_ok = i_tx_rst_n && i_push_frame && (ucnt_b != '0) && !q_full;
        occ_n = r.occ - (ucnt_a - ucnt_b);
        if (wr_en)  occ_n = occ_n + CNT_ONE;
        if (accept) occ_n = occ_n - CNT_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)     mem[r.wr_ptr]  <= i_data;
        if (commit_ok) len_q[r.q_wr]  <= ucnt_b;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r <= '0;
        end else if (!i_tx_rst_n) begin
            r <= '0;
        end else begin
            r.wr_ptr <= wr_ptr_b;
            r.occ    <= occ_n;
            if (commit_ok) begin
                r.ucnt     <= '0;
                r.mark     <= wr_ptr_b;
                r.mark_cnt <= '0;
                r.q_wr     <= r.q_wr + QP_ONE;
            end else begin
                r.ucnt <= ucnt_b;
                if (i_push_write_index) begin
                    r.mark     <= wr_ptr_b;
                    r.mark_cnt <= ucnt_b;
                end
            end
            r.q_cnt  <= r.q_cnt + (commit_ok ? QC_ONE : '0) - (q_pop ? QC_ONE : '0);
            r.frames <= r.frames + (commit_ok ? QC_ONE : '0) - (last_accept ? QC_ONE : '0);

            if (i_data_we && full) r.ovf <= 1'b1;
            if (i_push_frame && ucnt_b == '0) r.empty_err <= 1'b1;
            else if (i_push_frame && q_full)  r.qovf      <= 1'b1;

            case (r.fsm)
                IDLE: if (r.q_cnt != '0) r.fsm <= LOAD;
                LOAD: begin
                    r.q_rd      <= r.q_rd + QP_ONE;
                    r.remaining <= len_head;
                    r.dout      <= mem[r.rd_ptr];
                    r.valid     <= 1'b1;
                    r.sof       <= 1'b1;
                    r.eof       <= (len_head == CNT_ONE);
                    r.fsm       <= DATA;
                end
                DATA: if (accept) begin
                    r.rd_ptr <= r.rd_ptr + PTR_ONE;
                    if (r.remaining == CNT_ONE) begin
                        r.valid <= 1'b0;
                        r.sof   <= 1'b0;
                        r.eof   <= 1'b0;
                        r.sent  <= r.sent + 8'd1;
                        r.fsm   <= (r.q_cnt != '0) ? LOAD : IDLE;
                    end else begin
                        // Next read issued on acceptance keeps one byte per cycle.
                        r.dout      <= mem[r.rd_ptr + PTR_ONE];
                        r.sof       <= 1'b0;
                        r.eof       <= (r.remaining == CNT_TWO);
                        r.remaining <= r.remaining - CNT_ONE;
                    end
                end
                default: r.fsm <= IDLE;
            endcase
        end
    end

    assign o_byte         = r.dout;
    assign o_valid        = r.valid;
    assign o_sof          = r.sof;
    assign o_eof          = r.eof;
    assign o_data_size    = {{(15-ADDR_W){1'b0}}, r.occ};
    assign o_frames_count = {{(7-SLOT_W){1'b0}}, r.frames};
    assign o_status       = {r.sent, r.empty_err, r.qovf, r.ovf, (r.fsm != IDLE),
                             (r.frames == '0), q_full, (r.occ == '0), full};
endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed bench for tx_frame_buffer: host drives on negedge, outputs sampled on negedge.
module tb_tx_frame_buffer;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_tx_rst_n = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_data_we = 1'b0;
    logic        i_push_write_index = 1'b0;
    logic        i_pop_write_index = 1'b0;
    logic        i_push_frame = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] o_data_size;
    logic [7:0]  o_frames_count;
    logic [15:0] o_status;
    logic [7:0]  o_byte;
    logic        o_valid, o_sof, o_eof;

    int n_chk = 0;
    int n_fail = 0;
    int idx;
    logic [7:0] exp5 [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};

    tx_frame_buffer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tx_rst_n(i_tx_rst_n),
        .i_data(i_data), .i_data_we(i_data_we),
        .i_push_write_index(i_push_write_index), .i_pop_write_index(i_pop_write_index),
        .i_push_frame(i_push_frame), .o_data_size(o_data_size),
        .o_frames_count(o_frames_count), .o_status(o_status), .o_byte(o_byte),
        .o_valid(o_valid), .i_ready(i_ready), .o_sof(o_sof), .o_eof(o_eof)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic wr(input logic [7:0] b, input logic mk);
        i_data = b; i_data_we = 1'b1; i_push_write_index = mk;
        step();
        i_data_we = 1'b0; i_push_write_index = 1'b0;
    endtask

    task automatic commit();
        i_push_frame = 1'b1;
        step();
        i_push_frame = 1'b0;
    endtask

    task automatic flush();
        i_tx_rst_n = 1'b0;
        step();
        i_tx_rst_n = 1'b1;
    endtask

    // Wait (bounded) for a beat, compare {valid,sof,eof,byte}, then accept it.
    task automatic rx(input string tag, input logic [7:0] b, input logic s, input logic e);
        int n = 0;
        while (!o_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, {o_valid, o_sof, o_eof, o_byte}, {1'b1, s, e, b});
        i_ready = 1'b1;
        step();
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        // reset state and empty-commit error
        chk("rst_valid", o_valid, 0);
        chk("rst_byte", o_byte, 0);
        chk("rst_size", o_data_size, 0);
        chk("rst_frames", o_frames_count, 0);
        chk("rst_status", o_status, 16'h000A);
        commit();
        chk("empty_err_status", o_status, 16'h008A);
        chk("empty_err_frames", o_frames_count, 0);
        flush();
        chk("flush_status", o_status, 16'h000A);

        // basic three-byte frame and latency
        i_ready = 1'b1;
        wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
        chk("t1_size", o_data_size, 3);
        commit();
        chk("t1_lat0", o_valid, 0);
        chk("t1_frames", o_frames_count, 1);
        step();
        chk("t1_lat1", o_valid, 0);
        step();
        chk("t1_first", {o_valid, o_sof, o_eof, o_byte}, {3'b110, 8'h11});
        rx("t1_b0", 8'h11, 1, 0);
        rx("t1_b1", 8'h22, 0, 0);
        rx("t1_b2", 8'h33, 0, 1);
        chk("t1_size_end", o_data_size, 0);
        chk("t1_status_end", o_status, 16'h010A);

        // mark / rollback
        flush();
        wr(8'hA1, 0); wr(8'hA2, 1); wr(8'hA3, 0); wr(8'hA4, 0); wr(8'hA5, 0);
        chk("t2_size5", o_data_size, 5);
        i_pop_write_index = 1'b1;
        step();
        i_pop_write_index = 1'b0;
        chk("t2_size2", o_data_size, 2);
        commit();
        chk("t2_frames", o_frames_count, 1);
        rx("t2_b0", 8'hA1, 1, 0);
        rx("t2_b1", 8'hA2, 0, 1);
        chk("t2_size0", o_data_size, 0);
        chk("t2_status", o_status, 16'h010A);

        // fill to DEPTH plus one dropped byte
        flush();
        i_ready = 1'b0;
        for (int i = 0; i < 512; i++) wr(8'(i) ^ 8'h5A, 0);
        wr(8'hFF, 0);
        chk("t3_size", o_data_size, 512);
        chk("t3_status", o_status, 16'h0029);
        commit();
        for (int i = 0; i < 512; i++) rx("t3_beat", 8'(i) ^ 8'h5A, i == 0, i == 511);
        chk("t3_size0", o_data_size, 0);
        chk("t3_status_end", o_status, 16'h012A);

        // length queue overflow
        flush();
        i_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            i_data = 8'hB0 + 8'(k); i_data_we = 1'b1; i_push_frame = 1'b1;
            step();
            i_data_we = 1'b0; i_push_frame = 1'b0;
        end
        chk("t4_frames", o_frames_count, 8);
        chk("t4_size", o_data_size, 9);
        chk("t4_status", o_status, 16'h0054);
        for (int k = 0; k < 8; k++) rx("t4_beat", 8'hB0 + 8'(k), 1, 1);
        chk("t4_frames0", o_frames_count, 0);
        chk("t4_size1", o_data_size, 1);
        commit();
        rx("t4_last", 8'hB8, 1, 1);
        chk("t4_status_end", o_status, 16'h094A);

        // backpressure every other cycle
        flush();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) wr(exp5[k], 0);
        commit();
        idx = 0;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            i_ready = c[0];
            if (o_valid) begin
                chk("t5_beat", {o_sof, o_eof, o_byte}, {idx == 0, idx == 3, exp5[idx]});
                if (i_ready) idx++;
            end
            step();
        end
        chk("t5_count", idx, 4);
        chk("t5_frames", o_frames_count, 0);
        chk("t5_valid", o_valid, 0);

        // soft flush mid-send
        flush();
        i_ready = 1'b1;
        wr(8'hD0, 0); wr(8'hD1, 0); wr(8'hD2, 0); wr(8'hD3, 0);
        commit();
        rx("t6_b0", 8'hD0, 1, 0);
        rx("t6_b1", 8'hD1, 0, 0);
        chk("t6_pre", {o_valid, o_byte}, {1'b1, 8'hD2});
        flush();
        chk("t6_valid", o_valid, 0);
        chk("t6_size", o_data_size, 0);
        chk("t6_frames", o_frames_count, 0);
        chk("t6_status", o_status, 16'h000A);
        step(); step(); step();
        chk("t6_quiet", {o_valid, o_eof}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
